// File: rtl/priority_encoder_8to3.sv
// rtl/priority_encoder_8to3.sv - registered 8-to-3 priority encoder, highest set bit wins
module priority_encoder_8to3 (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in,
    output logic [2:0] out,
    output logic       valid
);

    logic [2:0] idx;
    logic       any;
    logic [2:0] out_d, out_q;
    logic       valid_d, valid_q;

    always_comb begin
        idx = 3'b000;
        casez (in)
            8'b1???_????: idx = 3'b111;
            8'b01??_????: idx = 3'b110;
            8'b001?_????: idx = 3'b101;
            8'b0001_????: idx = 3'b100;
            8'b0000_1???: idx = 3'b011;
            8'b0000_01??: idx = 3'b010;
            8'b0000_001?: idx = 3'b001;
            default:      idx = 3'b000;
        endcase
    end

    // idx already reads 0 for an empty vector; gating on any keeps that explicit
    always_comb begin
        any     = |in;
        out_d   = any ? idx : 3'b000;
        valid_d = any;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q   <= 3'b000;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign out   = out_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_priority_encoder_8to3.sv
// tb/tb_priority_encoder_8to3.sv - scoreboard bench for priority_encoder_8to3
module tb_priority_encoder_8to3;

    logic       clk;
    logic       rst;
    logic [7:0] in;
    logic [2:0] out;
    logic       valid;

    typedef struct {
        logic [7:0] in_v;
        logic [2:0] out_v;
        logic       valid_v;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    priority_encoder_8to3 dut (
        .clk   (clk),
        .rst   (rst),
        .in    (in),
        .out   (out),
        .valid (valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [2:0] ref_idx(input logic [7:0] v);
        for (int i = 7; i >= 0; i--)
            if (v[i]) return 3'(i);
        return 3'b000;
    endfunction

    task automatic drive(input logic [7:0] v, input logic r, input logic [2:0] eo,
                         input logic ev, input string nm);
        exp_t e;
        @(negedge clk);
        in  = v;
        rst = r;
        e.in_v = v; e.out_v = eo; e.valid_v = ev; e.name = nm;
        sb.push_back(e);
    endtask

    // Monitor: each drive produces exactly one registered result one edge later
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (out !== e.out_v) begin
                    errors++;
                    $display("FAIL %s out: in=%h got=%b want=%b", e.name, e.in_v, out, e.out_v);
                end
                checks++;
                if (valid !== e.valid_v) begin
                    errors++;
                    $display("FAIL %s valid: in=%h got=%b want=%b", e.name, e.in_v, valid, e.valid_v);
                end
            end
        end
    end

    initial begin
        logic [7:0] v;
        rst = 1'b1;
        in  = 8'hFF;

        drive(8'hFF, 1'b1, 3'b000, 1'b0, "reset0");
        drive(8'hFF, 1'b1, 3'b000, 1'b0, "reset1");
        drive(8'hFF, 1'b0, 3'b111, 1'b1, "post_reset");

        drive(8'h01, 1'b0, 3'd0, 1'b1, "onehot");
        drive(8'h02, 1'b0, 3'd1, 1'b1, "onehot");
        drive(8'h04, 1'b0, 3'd2, 1'b1, "onehot");
        drive(8'h08, 1'b0, 3'd3, 1'b1, "onehot");
        drive(8'h10, 1'b0, 3'd4, 1'b1, "onehot");
        drive(8'h20, 1'b0, 3'd5, 1'b1, "onehot");
        drive(8'h40, 1'b0, 3'd6, 1'b1, "onehot");
        drive(8'h80, 1'b0, 3'd7, 1'b1, "onehot");

        drive(8'b1100_0000, 1'b0, 3'b111, 1'b1, "prio_c0");
        drive(8'b0001_0110, 1'b0, 3'b100, 1'b1, "prio_16");
        drive(8'b0000_0011, 1'b0, 3'b001, 1'b1, "prio_03");

        drive(8'h00, 1'b0, 3'b000, 1'b0, "none");
        drive(8'h01, 1'b0, 3'b000, 1'b1, "bit0");
        drive(8'h00, 1'b0, 3'b000, 1'b0, "none_again");

        drive(8'h80, 1'b0, 3'b111, 1'b1, "mid_pre");
        drive(8'h80, 1'b1, 3'b000, 1'b0, "mid_reset");
        drive(8'h80, 1'b0, 3'b111, 1'b1, "mid_post");

        for (int i = 0; i < 256; i++) begin
            v = 8'(i);
            drive(v, 1'b0, ref_idx(v), |v, "exhaustive");
        end

        for (int k = 0; k < 10 && sb.size() != 0; k++) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: pending=%0d want=0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
